// File: rtl/io_access_ctrl_pkg.sv
// rtl/io_access_ctrl_pkg.sv - shared types, register map and RMW helper for io_access_ctrl
package io_access_ctrl_pkg;

   // I/O instruction codes; 6 and 7 are unassigned and rejected
   typedef enum logic [2:0] {
      OP_IN   = 3'd0,
      OP_OUT  = 3'd1,
      OP_SBI  = 3'd2,
      OP_CBI  = 3'd3,
      OP_SBIS = 3'd4,
      OP_SBIC = 3'd5
   } io_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } io_access_state_t;

   // I/O register map
   localparam logic [7:0] ADDR_DDRB  = 8'h00;
   localparam logic [7:0] ADDR_PORTB = 8'h01;
   localparam logic [7:0] ADDR_PINB  = 8'h02;
   localparam logic [7:0] ADDR_DDRC  = 8'h03;
   localparam logic [7:0] ADDR_PORTC = 8'h04;
   localparam logic [7:0] ADDR_PINC  = 8'h05;
   localparam logic [7:0] ADDR_DDRD  = 8'h06;
   localparam logic [7:0] ADDR_PORTD = 8'h07;
   localparam logic [7:0] ADDR_PIND  = 8'h08;

   // Set or clear one bit of a read value for the write-back half of SBI/CBI
   function automatic logic [7:0] rmw_bit(input logic [7:0] data,
                                          input logic [2:0] idx,
                                          input logic       set);
      logic [7:0] mask;
      mask = 8'd1 << idx;
      return set ? (data | mask) : (data & ~mask);
   endfunction

endpackage

// File: rtl/io_access_ctrl.sv
// rtl/io_access_ctrl.sv - I/O bus initiator FSM for IN/OUT/SBI/CBI; IO_BIT_TEST_EN adds SBIS/SBIC
module io_access_ctrl
   import io_access_ctrl_pkg::*;
#(
   parameter logic [7:0] IO_ADDR_MAX = 8'h08
) (
   input  logic       clock,
   input  logic       reset_s2_n,
   input  logic       req,
   input  logic [2:0] op,
   input  logic [7:0] io_address,
   input  logic [2:0] bit_index,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       ack,
   output logic [7:0] rd_data,
   output logic       error,
   output logic       skip,
   output logic [7:0] bus_address,
   output logic [7:0] bus_write_data,
   output logic       bus_write_enable,
   input  logic [7:0] bus_read_data
);

   io_access_state_t state;
   io_op_t           op_q;
   logic [7:0]       addr_q;
   logic [2:0]       bit_q;
   io_op_t           op_in;

   assign op_in = io_op_t'(op);

   function automatic logic op_legal(input io_op_t o);
`ifdef IO_BIT_TEST_EN
      return (o == OP_IN) || (o == OP_OUT) || (o == OP_SBI) || (o == OP_CBI) ||
             (o == OP_SBIS) || (o == OP_SBIC);
`else
      return (o == OP_IN) || (o == OP_OUT) || (o == OP_SBI) || (o == OP_CBI);
`endif
   endfunction

   // Bus strobes decode straight from the state register so an async reset drops them at once
   assign busy             = (state != ST_IDLE);
   assign ack              = (state == ST_DONE);
   assign bus_write_enable = (state == ST_WRITE);
   assign bus_address      = ((state == ST_READ) || (state == ST_WRITE)) ? addr_q : 8'h00;

   // Transaction sequencer: accept, read, optional write-back, single-cycle completion
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         state          <= ST_IDLE;
         op_q           <= OP_IN;
         addr_q         <= 8'h00;
         bit_q          <= 3'd0;
         rd_data        <= 8'h00;
         bus_write_data <= 8'h00;
         error          <= 1'b0;
         skip           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               error <= 1'b0;
               skip  <= 1'b0;
               if (req) begin
                  op_q   <= op_in;
                  addr_q <= io_address;
                  bit_q  <= bit_index;
                  if (!op_legal(op_in) || (io_address > IO_ADDR_MAX)) begin
                     error   <= 1'b1;
                     rd_data <= 8'h00;
                     state   <= ST_DONE;
                  end else if (op_in == OP_OUT) begin
                     bus_write_data <= wr_data;
                     state          <= ST_WRITE;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               case (op_q)
                  OP_SBI: begin
                     bus_write_data <= rmw_bit(bus_read_data, bit_q, 1'b1);
                     state          <= ST_WRITE;
                  end
                  OP_CBI: begin
                     bus_write_data <= rmw_bit(bus_read_data, bit_q, 1'b0);
                     state          <= ST_WRITE;
                  end
`ifdef IO_BIT_TEST_EN
                  OP_SBIS: begin
                     skip  <= bus_read_data[bit_q];
                     state <= ST_DONE;
                  end
                  OP_SBIC: begin
                     skip  <= ~bus_read_data[bit_q];
                     state <= ST_DONE;
                  end
`endif
                  default: begin
                     rd_data <= bus_read_data;
                     state   <= ST_DONE;
                  end
               endcase
            end
            ST_WRITE: begin
               state <= ST_DONE;
            end
            ST_DONE: begin
               error <= 1'b0;
               skip  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_access_ctrl.sv
// tb/tb_io_access_ctrl.sv - directed vector bench for io_access_ctrl with an I/O memory model
module tb_io_access_ctrl;

   logic       clock = 1'b0;
   logic       reset_s2_n = 1'b0;
   logic       req = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] io_address = 8'h00;
   logic [2:0] bit_index = 3'd0;
   logic [7:0] wr_data = 8'h00;
   logic       busy, ack, error, skip, bus_write_enable;
   logic [7:0] rd_data, bus_address, bus_write_data, bus_read_data;

   logic [7:0] mem [0:255] = '{default: 8'h00};
   logic [7:0] exp_mem [0:8];
   int         we_count = 0;
   int         ack_count = 0;
   int         checks = 0;
   int         errors = 0;

   io_access_ctrl #(.IO_ADDR_MAX(8'h08)) dut (
      .clock(clock), .reset_s2_n(reset_s2_n), .req(req), .op(op),
      .io_address(io_address), .bit_index(bit_index), .wr_data(wr_data),
      .busy(busy), .ack(ack), .rd_data(rd_data), .error(error), .skip(skip),
      .bus_address(bus_address), .bus_write_data(bus_write_data),
      .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data)
   );

   always #10 clock = ~clock;

   assign bus_read_data = mem[bus_address];

   always @(posedge clock) begin
      if (bus_write_enable === 1'b1) begin
         mem[bus_address] <= bus_write_data;
         we_count <= we_count + 1;
      end
      if (ack === 1'b1) ack_count <= ack_count + 1;
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] addr;
      logic [2:0] bitn;
      logic [7:0] wdata;
      int         lat;
      logic       err;
      logic       skp;
      logic [7:0] rd;
      int         writes;
      logic [7:0] mem_val;
   } vec_t;

   vec_t vecs [0:13];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_mem(input string name);
      int bad;
      bad = 0;
      for (int a = 0; a < 9; a++) if (mem[a] !== exp_mem[a]) bad++;
      check(name, bad, 0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      int we0;
      we0 = we_count;
      @(negedge clock);
      req = 1'b1; op = v.op; io_address = v.addr; bit_index = v.bitn; wr_data = v.wdata;
      @(posedge clock);
      #1 req = 1'b0;
      lat = 99;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clock);
         if (n == 1) check($sformatf("v%0d_busy", idx), int'(busy), 1);
         if (ack === 1'b1) begin lat = n; break; end
      end
      check($sformatf("v%0d_latency", idx), lat, v.lat);
      check($sformatf("v%0d_error", idx), int'(error), int'(v.err));
      check($sformatf("v%0d_skip", idx), int'(skip), int'(v.skp));
      check($sformatf("v%0d_rd_data", idx), int'(rd_data), int'(v.rd));
      check($sformatf("v%0d_writes", idx), we_count - we0, v.writes);
      if (v.writes == 1) exp_mem[v.addr] = v.mem_val;
      @(negedge clock);
      check($sformatf("v%0d_ack_clear", idx), int'(ack), 0);
      check($sformatf("v%0d_idle", idx), int'({busy, error, skip}), 0);
      check_mem($sformatf("v%0d_memory", idx));
   endtask

   initial begin
      int we0;
      int ack0;
      for (int a = 0; a < 9; a++) exp_mem[a] = 8'h00;

      //          op     addr   bit   wdata  lat err skp rd     wr val
      vecs[0]  = '{3'd1, 8'h00, 3'd0, 8'hFF, 2, 1'b0, 1'b0, 8'h00, 1, 8'hFF};
      vecs[1]  = '{3'd1, 8'h01, 3'd0, 8'h0F, 2, 1'b0, 1'b0, 8'h00, 1, 8'h0F};
      vecs[2]  = '{3'd2, 8'h01, 3'd7, 8'h00, 3, 1'b0, 1'b0, 8'h00, 1, 8'h8F};
      vecs[3]  = '{3'd3, 8'h01, 3'd0, 8'h00, 3, 1'b0, 1'b0, 8'h00, 1, 8'h8E};
      vecs[4]  = '{3'd0, 8'h09, 3'd0, 8'h00, 1, 1'b1, 1'b0, 8'h00, 0, 8'h00};
      vecs[5]  = '{3'd7, 8'h00, 3'd0, 8'h00, 1, 1'b1, 1'b0, 8'h00, 0, 8'h00};
      vecs[6]  = '{3'd6, 8'h01, 3'd0, 8'h00, 1, 1'b1, 1'b0, 8'h00, 0, 8'h00};
      vecs[7]  = '{3'd0, 8'h01, 3'd5, 8'h00, 2, 1'b0, 1'b0, 8'h8E, 0, 8'h00};
      vecs[8]  = '{3'd1, 8'h05, 3'd5, 8'h08, 2, 1'b0, 1'b0, 8'h8E, 1, 8'h08};
      vecs[9]  = '{3'd0, 8'h05, 3'd0, 8'h00, 2, 1'b0, 1'b0, 8'h08, 0, 8'h00};
`ifdef IO_BIT_TEST_EN
      vecs[10] = '{3'd4, 8'h05, 3'd3, 8'h00, 2, 1'b0, 1'b1, 8'h08, 0, 8'h00};
      vecs[11] = '{3'd5, 8'h05, 3'd3, 8'h00, 2, 1'b0, 1'b0, 8'h08, 0, 8'h00};
      vecs[12] = '{3'd1, 8'h08, 3'd0, 8'h55, 2, 1'b0, 1'b0, 8'h08, 1, 8'h55};
      vecs[13] = '{3'd3, 8'h08, 3'd0, 8'h00, 3, 1'b0, 1'b0, 8'h08, 1, 8'h54};
`else
      vecs[10] = '{3'd4, 8'h05, 3'd3, 8'h00, 1, 1'b1, 1'b0, 8'h00, 0, 8'h00};
      vecs[11] = '{3'd5, 8'h05, 3'd3, 8'h00, 1, 1'b1, 1'b0, 8'h00, 0, 8'h00};
      vecs[12] = '{3'd1, 8'h08, 3'd0, 8'h55, 2, 1'b0, 1'b0, 8'h00, 1, 8'h55};
      vecs[13] = '{3'd3, 8'h08, 3'd0, 8'h00, 3, 1'b0, 1'b0, 8'h00, 1, 8'h54};
`endif

      // reset state
      repeat (2) @(negedge clock);
      check("reset_outputs", int'({busy, ack, error, skip, bus_write_enable}), 0);
      check("reset_rd_data", int'(rd_data), 0);
      check("reset_bus_address", int'(bus_address), 0);
      check("reset_bus_write_data", int'(bus_write_data), 0);
      reset_s2_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // second request one cycle into an OUT is dropped
      we0 = we_count; ack0 = ack_count;
      @(negedge clock);
      req = 1'b1; op = 3'd1; io_address = 8'h02; wr_data = 8'h11;
      @(posedge clock);
      #1 wr_data = 8'h22;
      @(posedge clock);
      #1 req = 1'b0;
      repeat (6) @(negedge clock);
      exp_mem[2] = 8'h11;
      check("busy_req_acks", ack_count - ack0, 1);
      check("busy_req_writes", we_count - we0, 1);
      check_mem("busy_req_memory");

      // reset during the write-back cycle of an SBI on DDRC
      we0 = we_count;
      @(negedge clock);
      req = 1'b1; op = 3'd2; io_address = 8'h03; bit_index = 3'd2;
      @(posedge clock);
      #1 req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_write_we_before", int'(bus_write_enable), 1);
      #2 reset_s2_n = 1'b0;
      #1;
      check("rst_write_we_async", int'(bus_write_enable), 0);
      check("rst_write_outputs", int'({busy, ack, error, skip}), 0);
      check("rst_write_rd_data", int'(rd_data), 0);
      check("rst_write_bus", int'({bus_address, bus_write_data}), 0);
      @(posedge clock);
      @(negedge clock);
      check("rst_write_writes", we_count - we0, 0);
      check_mem("rst_write_memory");
      reset_s2_n = 1'b1;
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
